port_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one single-ported resource, such as the data-memory or peripheral bus port, between four requesters. It drives the 2-bit select of the shared 4-input data multiplexer and a one-hot grant. It sequences each transaction with a start pulse and a completion ack, and includes a watchdog that releases the port if the resource never signals completion.

---
 rtl/port_rr_arbiter_pkg.sv | 17 +
 rtl/port_rr_arbiter_rr_pick4.sv | 37 +++
 rtl/port_rr_arbiter.sv | 151 +++++++++++++++
 tb/tb_port_rr_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/port_rr_arbiter_pkg.sv
// Shared definitions for the four-way round-robin port arbiter.
//   NUM_REQ          number of requesters sharing the port
//   SEL_W            width of the binary mux select
//   DEFAULT_TIMEOUT  default watchdog limit in BUSY cycles (0 = off)
//   state_t          arbiter FSM encoding
package port_rr_arbiter_pkg;

   localparam int NUM_REQ         = 4;
   localparam int SEL_W           = 2;
   localparam int DEFAULT_TIMEOUT = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/port_rr_arbiter_rr_pick4.sv
// Combinational round-robin pick over four requesters.
// Ports:
//   req [3:0]  request vector
//   ptr [1:0]  highest-priority index for this arbitration
//   any        at least one request is set
//   idx [1:0]  first set request found scanning ptr, ptr+1, ... mod 4
module rr_pick4
   import port_rr_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   output logic               any,
   output logic [SEL_W-1:0]   idx
);

   logic [2*NUM_REQ-1:0] dbl;
   logic [NUM_REQ-1:0]   rot;
   logic [SEL_W-1:0]     off;

   // Duplicating the vector makes the rotate a plain part-select:
   // rot[i] corresponds to req[(ptr+i) mod 4].
   assign dbl = {req, req};
   assign rot = dbl[{1'b0, ptr} +: NUM_REQ];

   // Lowest set bit of the rotated vector wins.
   always_comb begin
      off = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot[i]) off = SEL_W'(i);
      end
   end

   assign any = |req;
   // 2-bit add wraps naturally, undoing the rotation.
   assign idx = ptr + off;

endmodule

// File: rtl/port_rr_arbiter.sv
// Round-robin arbiter for one single-ported resource shared by four
// requesters, with start/ack transaction sequencing and a watchdog.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no owner; arbitrate among req_i each cycle
// BUSY    | cur owns the port until done_i or watchdog expiry
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   req_i      level request per requester
//   done_i     completion strobe from the resource (BUSY only)
//   grant_o    one-hot grant, zero when idle
//   select_o   binary index of the owner; holds its value in IDLE
//   start_o    pulse in the first BUSY cycle
//   busy_o     high while BUSY
//   ack_o      one-cycle completion pulse to the owner
//   error_o    one-cycle pulse on watchdog expiry
//   err_id_o   owner aborted by the watchdog, valid with error_o
module port_rr_arbiter
   import port_rr_arbiter_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
)(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               done_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [SEL_W-1:0]   select_o,
   output logic               start_o,
   output logic               busy_o,
   output logic [NUM_REQ-1:0] ack_o,
   output logic               error_o,
   output logic [SEL_W-1:0]   err_id_o
);

   localparam int              CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit              WD_EN    = (TIMEOUT > 0);
   localparam logic [CNT_W-1:0] CNT_LAST = WD_EN ? CNT_W'(TIMEOUT - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   ptr_q, ptr_d;
   logic [SEL_W-1:0]   cur_q, cur_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [SEL_W-1:0]   select_q, select_d;
   logic               start_q, start_d;
   logic               busy_q, busy_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic               error_q, error_d;
   logic [SEL_W-1:0]   err_id_q, err_id_d;

   logic               pick_any;
   logic [SEL_W-1:0]   pick_idx;

   rr_pick4 u_pick (
      .req (req_i),
      .ptr (ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      cur_d    = cur_q;
      cnt_d    = cnt_q;
      grant_d  = grant_q;
      select_d = select_q;
      start_d  = 1'b0;
      busy_d   = busy_q;
      ack_d    = '0;
      error_d  = 1'b0;
      err_id_d = err_id_q;

      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               state_d  = ST_BUSY;
               cur_d    = pick_idx;
               grant_d  = NUM_REQ'(1) << pick_idx;
               select_d = pick_idx;
               start_d  = 1'b1;
               busy_d   = 1'b1;
               cnt_d    = '0;
            end
         end
         ST_BUSY: begin
            // done_i is checked first so it wins over a same-cycle expiry.
            if (done_i) begin
               ack_d   = NUM_REQ'(1) << cur_q;
               state_d = ST_IDLE;
               grant_d = '0;
               busy_d  = 1'b0;
               ptr_d   = cur_q + SEL_ONE;
            end else if (WD_EN && (cnt_q == CNT_LAST)) begin
               error_d  = 1'b1;
               err_id_d = cur_q;
               state_d  = ST_IDLE;
               grant_d  = '0;
               busy_d   = 1'b0;
               ptr_d    = cur_q + SEL_ONE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         cur_q    <= '0;
         cnt_q    <= '0;
         grant_q  <= '0;
         select_q <= '0;
         start_q  <= 1'b0;
         busy_q   <= 1'b0;
         ack_q    <= '0;
         error_q  <= 1'b0;
         err_id_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         cur_q    <= cur_d;
         cnt_q    <= cnt_d;
         grant_q  <= grant_d;
         select_q <= select_d;
         start_q  <= start_d;
         busy_q   <= busy_d;
         ack_q    <= ack_d;
         error_q  <= error_d;
         err_id_q <= err_id_d;
      end
   end

   assign grant_o  = grant_q;
   assign select_o = select_q;
   assign start_o  = start_q;
   assign busy_o   = busy_q;
   assign ack_o    = ack_q;
   assign error_o  = error_q;
   assign err_id_o = err_id_q;

endmodule

// File: tb/tb_port_rr_arbiter.sv
// Bench for port_rr_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all compared each cycle against a
// transaction-level model of the arbitration rules.
module tb_port_rr_arbiter;

   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic       done = 1'b0;

   logic [3:0] grant_o;
   logic [1:0] select_o;
   logic       start_o;
   logic       busy_o;
   logic [3:0] ack_o;
   logic       error_o;
   logic [1:0] err_id_o;

   int checks = 0;
   int errors = 0;

   port_rr_arbiter #(.TIMEOUT(TO)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .req_i    (req),
      .done_i   (done),
      .grant_o  (grant_o),
      .select_o (select_o),
      .start_o  (start_o),
      .busy_o   (busy_o),
      .ack_o    (ack_o),
      .error_o  (error_o),
      .err_id_o (err_id_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: who owns the port, how many BUSY cycles have elapsed, and
   // where the round-robin scan starts next.
   bit         m_on = 1'b0;
   bit         m_busy = 1'b0;
   int         m_own = 0;
   int         m_elapsed = 0;
   int         m_ptr = 0;
   logic [3:0] e_grant = '0;
   logic [3:0] e_ack = '0;
   int         e_sel = 0;
   int         e_errid = 0;
   bit         e_start = 1'b0;
   bit         e_busy = 1'b0;
   bit         e_err = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_on = 1'b1; m_busy = 1'b0; m_ptr = 0; m_own = 0;
         e_grant = '0; e_sel = 0; e_start = 1'b0; e_busy = 1'b0;
         e_ack = '0; e_err = 1'b0; e_errid = 0;
      end else if (m_on) begin
         e_start = 1'b0; e_ack = '0; e_err = 1'b0;
         if (!m_busy) begin
            for (int k = 0; k < 4; k++) begin
               if (!m_busy && req[(m_ptr + k) % 4]) begin
                  m_busy = 1'b1;
                  m_own = (m_ptr + k) % 4;
                  m_elapsed = 0;
                  e_grant = 4'b0001 << m_own;
                  e_sel = m_own;
                  e_start = 1'b1;
                  e_busy = 1'b1;
               end
            end
         end else begin
            m_elapsed++;
            if (done || (TO > 0 && m_elapsed == TO)) begin
               if (done) e_ack = 4'b0001 << m_own;
               else begin
                  e_err = 1'b1;
                  e_errid = m_own;
               end
               m_busy = 1'b0;
               e_grant = '0;
               e_busy = 1'b0;
               m_ptr = (m_own + 1) % 4;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_on) begin
         chk("m_grant", grant_o, e_grant);
         chk("m_select", select_o, e_sel);
         chk("m_start", start_o, e_start);
         chk("m_busy", busy_o, e_busy);
         chk("m_ack", ack_o, e_ack);
         chk("m_error", error_o, e_err);
         if (e_err) chk("m_err_id", err_id_o, e_errid);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      chk("rst_grant", grant_o, 0);
      chk("rst_select", select_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_start", start_o, 0);
      chk("rst_ack", ack_o, 0);
      chk("rst_error", error_o, 0);

      // done in IDLE does nothing
      done = 1'b1; tick(); done = 1'b0;
      chk("idle_done_busy", busy_o, 0);
      chk("idle_done_ack", ack_o, 0);

      // Single requester 2, completion in 3rd BUSY cycle
      req = 4'b0100; tick();
      chk("r2_grant", grant_o, 4'b0100);
      chk("r2_select", select_o, 2);
      chk("r2_start", start_o, 1);
      tick();
      chk("r2_start_low", start_o, 0);
      chk("r2_grant_hold", grant_o, 4'b0100);
      tick();
      done = 1'b1; req = 4'b0000; tick(); done = 1'b0;
      chk("r2_ack", ack_o, 4'b0100);
      chk("r2_busy_off", busy_o, 0);
      chk("r2_select_hold", select_o, 2);

      // Wrap from ptr=3 to requester 0, then 1
      req = 4'b0011; tick();
      chk("wrap_grant0", grant_o, 4'b0001);
      done = 1'b1; tick(); done = 1'b0;
      chk("wrap_ack0", ack_o, 4'b0001);
      tick();
      chk("wrap_grant1", grant_o, 4'b0010);
      done = 1'b1; req = 4'b0000; tick(); done = 1'b0;
      chk("wrap_ack1", ack_o, 4'b0010);

      // Fairness from ptr=0 with everyone requesting
      rst = 1'b1; tick(); rst = 1'b0;
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("fair_grant", grant_o, 4'b0001 << (i % 4));
         chk("fair_start", start_o, 1);
         done = 1'b1; tick(); done = 1'b0;
         chk("fair_ack", ack_o, 4'b0001 << (i % 4));
         chk("fair_gap", grant_o, 0);
         if (i == 4) req = 4'b0000;
      end

      // Watchdog expiry on requester 1
      req = 4'b0010; tick();
      chk("wd_grant", grant_o, 4'b0010);
      tick(); tick(); tick();
      chk("wd_still_busy", busy_o, 1);
      chk("wd_no_err_yet", error_o, 0);
      tick(); req = 4'b0000;
      chk("wd_error", error_o, 1);
      chk("wd_err_id", err_id_o, 1);
      chk("wd_no_ack", ack_o, 0);
      chk("wd_release", grant_o, 0);
      tick();
      chk("wd_err_pulse", error_o, 0);

      // ptr is 2 after the abort: 2 beats 1
      req = 4'b0110; tick();
      chk("wd_ptr", grant_o, 4'b0100);
      done = 1'b1; req = 4'b0000; tick(); done = 1'b0;

      // done coinciding with the last watchdog cycle
      req = 4'b0010; tick(); tick(); tick(); tick();
      done = 1'b1; req = 4'b0000; tick(); done = 1'b0;
      chk("tie_ack", ack_o, 4'b0010);
      chk("tie_error", error_o, 0);

      // Reset in 2nd BUSY cycle
      req = 4'b0001; tick(); tick();
      rst = 1'b1; tick(); rst = 1'b0;
      chk("mid_rst_grant", grant_o, 0);
      chk("mid_rst_ack", ack_o, 0);
      chk("mid_rst_error", error_o, 0);
      chk("mid_rst_busy", busy_o, 0);
      tick();
      chk("post_rst_grant", grant_o, 4'b0001);
      chk("post_rst_start", start_o, 1);
      done = 1'b1; req = 4'b0000; tick(); done = 1'b0;
      chk("post_rst_ack", ack_o, 4'b0001);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
         done = ($urandom_range(0, 4) == 0);
         tick();
      end
      rst = 1'b0; req = 4'b0000; done = 1'b0;
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
